// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator: standard mode sets and helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package vga_timing_pkg;

   typedef struct packed {
      logic [15:0] sync;
      logic [15:0] back;
      logic [15:0] act;
      logic [15:0] front;
   } axis_t;

   typedef struct packed {
      axis_t h;
      axis_t v;
   } mode_t;

   localparam mode_t MODE_640X480_60 = '{
      h: '{sync: 16'd96,  back: 16'd48,  act: 16'd640,  front: 16'd16},
      v: '{sync: 16'd2,   back: 16'd33,  act: 16'd480,  front: 16'd10}};

   localparam mode_t MODE_800X600_60 = '{
      h: '{sync: 16'd128, back: 16'd88,  act: 16'd800,  front: 16'd40},
      v: '{sync: 16'd4,   back: 16'd23,  act: 16'd600,  front: 16'd1}};

   localparam mode_t MODE_1024X768_60 = '{
      h: '{sync: 16'd136, back: 16'd160, act: 16'd1024, front: 16'd24},
      v: '{sync: 16'd6,   back: 16'd29,  act: 16'd768,  front: 16'd3}};

   // Total counts per line (or lines per frame).
   function automatic int timing_total(input int sync, input int back, input int act, input int front);
      return sync + back + act + front;
   endfunction

   // Counter value of the first visible pixel (or line).
   function automatic int act_start(input int sync, input int back);
      return sync + back;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that advances only on ce; DEPTH=0 is a straight wire.
// Latency: DEPTH ce-cycles.
// Backpressure: none; ce=0 holds every stage.
// Ports: clk, rst_n (async, active-low, clears to RST_VAL), ce, d in; q out.
module vga_delay_line
   import vga_timing_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n, ce};
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] sr_q [DEPTH];
         logic [WIDTH-1:0] sr_d [DEPTH];

         always_comb begin
            sr_d = sr_q;
            if (ce) begin
               sr_d[0] = d;
               for (int i = 1; i < DEPTH; i++) begin
                  sr_d[i] = sr_q[i-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  sr_q[i] <= RST_VAL;
               end
            end else begin
               sr_q <= sr_d;
            end
         end

         assign q = sr_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with fetch lookahead: req/req_x/req_y lead the display outputs by LAT pixels.
// Latency: fetch stage 1 clk after the ce that samples the counters; display stage LAT ce-cycles after that.
// Backpressure: none; ce=0 freezes all state, outputs hold and strobes drop until the next ce.
// Ports: clk, rst_n, ce in; req, req_x, req_y (fetch side); hs, vs, de, pix_x, pix_y, line_start, frame_start (display side).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_SYNC  = 136,
   parameter int   H_BACK  = 160,
   parameter int   H_ACT   = 1024,
   parameter int   H_FRONT = 24,
   parameter int   V_SYNC  = 6,
   parameter int   V_BACK  = 29,
   parameter int   V_ACT   = 768,
   parameter int   V_FRONT = 3,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   LAT     = 2,
   parameter int   CW      = 11
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   output logic          req,
   output logic [CW-1:0] req_x,
   output logic [CW-1:0] req_y,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOT = timing_total(H_SYNC, H_BACK, H_ACT, H_FRONT);
   localparam int V_TOT = timing_total(V_SYNC, V_BACK, V_ACT, V_FRONT);
   localparam int H_ST  = act_start(H_SYNC, H_BACK);
   localparam int V_ST  = act_start(V_SYNC, V_BACK);
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int BW    = 5 + 2 * CW;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
   localparam logic [HW-1:0] H_OFS  = HW'(H_ST);
   localparam logic [VW-1:0] V_OFS  = VW'(V_ST);

   // Raster counters
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (ce) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   // Fetch stage: region decode of the current counters, loaded on ce
   logic          req_q, req_d;
   logic [CW-1:0] req_x_q, req_x_d;
   logic [CW-1:0] req_y_q, req_y_d;
   logic          hsync0_q, hsync0_d;
   logic          vsync0_q, vsync0_d;
   logic          h0_q, h0_d;
   logic          f0_q, f0_d;
   logic          h_act, v_act;

   always_comb begin
      h_act    = (int'(h_cnt_q) >= H_ST) && (int'(h_cnt_q) < H_ST + H_ACT);
      v_act    = (int'(v_cnt_q) >= V_ST) && (int'(v_cnt_q) < V_ST + V_ACT);
      req_d    = req_q;
      req_x_d  = req_x_q;
      req_y_d  = req_y_q;
      hsync0_d = hsync0_q;
      vsync0_d = vsync0_q;
      h0_d     = h0_q;
      f0_d     = f0_q;
      if (ce) begin
         req_d    = h_act && v_act;
         // Offset removed at counter width, then resized to the coordinate width.
         req_x_d  = req_d ? CW'(h_cnt_q - H_OFS) : '0;
         req_y_d  = req_d ? CW'(v_cnt_q - V_OFS) : '0;
         hsync0_d = int'(h_cnt_q) < H_SYNC;
         vsync0_d = int'(v_cnt_q) < V_SYNC;
         h0_d     = (h_cnt_q == '0);
         f0_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   // Display stage: fetch-stage bundle delayed LAT ce-cycles
   logic [BW-1:0] s0_bus, disp_bus;
   logic          disp_hsync, disp_vsync, disp_de, disp_h0, disp_f0;
   logic [CW-1:0] disp_x, disp_y;

   assign s0_bus = {hsync0_q, vsync0_q, req_q, req_x_q, req_y_q, h0_q, f0_q};

   vga_delay_line #(
      .WIDTH   (BW),
      .DEPTH   (LAT),
      .RST_VAL ({BW{1'b0}})
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .d     (s0_bus),
      .q     (disp_bus)
   );

   assign {disp_hsync, disp_vsync, disp_de, disp_x, disp_y, disp_h0, disp_f0} = disp_bus;

   // The delayed coordinate is zero outside the visible area, so the last
   // visible coordinate is kept separately to give pix_x/pix_y their hold behaviour.
   logic [CW-1:0] hold_x_q, hold_x_d;
   logic [CW-1:0] hold_y_q, hold_y_d;
   // Set only in the clk right after a ce edge, so strobes never stretch across ce=0.
   logic          loaded_q, loaded_d;

   always_comb begin
      hold_x_d = disp_de ? disp_x : hold_x_q;
      hold_y_d = disp_de ? disp_y : hold_y_q;
      loaded_d = ce;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         req_q    <= 1'b0;
         req_x_q  <= '0;
         req_y_q  <= '0;
         hsync0_q <= 1'b0;
         vsync0_q <= 1'b0;
         h0_q     <= 1'b0;
         f0_q     <= 1'b0;
         hold_x_q <= '0;
         hold_y_q <= '0;
         loaded_q <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         req_q    <= req_d;
         req_x_q  <= req_x_d;
         req_y_q  <= req_y_d;
         hsync0_q <= hsync0_d;
         vsync0_q <= vsync0_d;
         h0_q     <= h0_d;
         f0_q     <= f0_d;
         hold_x_q <= hold_x_d;
         hold_y_q <= hold_y_d;
         loaded_q <= loaded_d;
      end
   end

   assign req         = req_q;
   assign req_x       = req_x_q;
   assign req_y       = req_y_q;
   assign hs          = disp_hsync ? HS_POL : ~HS_POL;
   assign vs          = disp_vsync ? VS_POL : ~VS_POL;
   assign de          = disp_de;
   assign pix_x       = disp_de ? disp_x : hold_x_q;
   assign pix_y       = disp_de ? disp_y : hold_y_q;
   assign line_start  = loaded_q & disp_h0;
   assign frame_start = loaded_q & disp_f0;

endmodule
